// File: rtl/serializador_sincronia_pkg.sv
// Shared definitions for the sync-word serial framer.
//   - estado_t  : framer phase (SYNC, DATOS, REINICIO)
//   - *_DEF     : default word width, sync/fill word and desync word
//   - ancho_cnt : width of a counter that walks 0..ancho-1
package serializador_sincronia_pkg;

   typedef enum logic [1:0] {
      SYNC     = 2'd0,
      DATOS    = 2'd1,
      REINICIO = 2'd2
   } estado_t;

   localparam int         ANCHO_DEF        = 5;
   localparam logic [4:0] SECUENCIA_DEF    = 5'b10100;
   localparam logic [4:0] SEC_REINICIO_DEF = 5'b00000;

   function automatic int ancho_cnt(input int ancho);
      return (ancho <= 2) ? 1 : $clog2(ancho);
   endfunction

endpackage

// File: rtl/serializador_sincronia_contador.sv
// Bit position counter for the framer: walks 0..ANCHO-1 and flags the word
// boundary cycle, i.e. the cycle whose closing edge loads the next word.
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high clear
//   limite_o : high in a boundary cycle (last bit of a word, or the first
//              cycle after reset released)
module contador_bits
   import serializador_sincronia_pkg::*;
#(
   parameter int ANCHO = ANCHO_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic limite_o
);

   localparam int             CW     = ancho_cnt(ANCHO);
   localparam logic [CW-1:0]  ULTIMO = CW'(ANCHO - 1);
   localparam logic [CW-1:0]  UNO    = CW'(1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          primero_q;

   // After reset no word is in flight, so the very first edge is a boundary.
   assign limite_o = primero_q || (cnt_q == ULTIMO);

   always_comb begin
      cnt_d = limite_o ? '0 : cnt_q + UNO;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         primero_q <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         primero_q <= 1'b0;
      end
   end

endmodule

// File: rtl/serializador_sincronia.sv
// Serial framer feeding the sync-word detector. Sends SECUENCIA SYNC_COUNT
// times after reset, then data words (valid/ready), SECUENCIA as fill when
// idle, and SEC_REINICIO once on request to knock the detector out of sync.
//   clk, rst      : clock and synchronous active-high reset
//   dato          : word to send, taken when dato_valido && dato_listo
//   dato_valido   : dato holds a word
//   dato_listo    : word accepted at this edge (boundary cycles only)
//   desincronizar : one-cycle request to send SEC_REINICIO
//   s_out         : registered serial stream, MSB first
//   sincronizado  : high during the data phase
//   error_dato    : one-cycle pulse when a word equal to SEC_REINICIO is dropped
module serializador_sincronia
   import serializador_sincronia_pkg::*;
#(
   parameter int               ANCHO        = ANCHO_DEF,
   parameter logic [ANCHO-1:0] SECUENCIA    = SECUENCIA_DEF,
   parameter logic [ANCHO-1:0] SEC_REINICIO = SEC_REINICIO_DEF,
   parameter int               SYNC_COUNT   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ANCHO-1:0] dato,
   input  logic             dato_valido,
   output logic             dato_listo,
   input  logic             desincronizar,
   output logic             s_out,
   output logic             sincronizado,
   output logic             error_dato
);

   localparam logic [3:0] SYNC_OBJ = 4'(SYNC_COUNT);

   estado_t          estado_q, estado_d;
   logic [3:0]       sync_cnt_q, sync_cnt_d;
   logic             pend_q, pend_d;
   logic [ANCHO-1:0] shreg_q, shreg_d;
   logic             s_out_q, sinc_q, err_q, err_d;
   logic             limite, fin_sync, en_datos;

   contador_bits #(.ANCHO(ANCHO)) u_contador (
      .clk_i    (clk),
      .rst_i    (rst),
      .limite_o (limite)
   );

   // The boundary that closes the last sync word already selects like DATOS,
   // so the first data word can be accepted there without a gap word.
   assign fin_sync   = (estado_q == SYNC) && (sync_cnt_q == SYNC_OBJ);
   assign en_datos   = (estado_q == DATOS) || fin_sync;
   assign dato_listo = limite && en_datos && !pend_q && !desincronizar && !rst;

   always_comb begin
      estado_d   = estado_q;
      sync_cnt_d = sync_cnt_q;
      pend_d     = pend_q;
      err_d      = 1'b0;
      shreg_d    = {shreg_q[ANCHO-2:0], 1'b0};

      // Requests only count in the data phase; a second one while pending is moot.
      if ((estado_q == DATOS) && desincronizar && !pend_q) begin
         pend_d = 1'b1;
      end

      if (limite) begin
         if (en_datos) begin
            estado_d = DATOS;
            if (pend_q) begin
               shreg_d  = SEC_REINICIO;
               pend_d   = 1'b0;
               estado_d = REINICIO;
            end else if (dato_listo && dato_valido) begin
               // Sending the desync word as data would drop the detector's lock.
               if (dato == SEC_REINICIO) begin
                  shreg_d = SECUENCIA;
                  err_d   = 1'b1;
               end else begin
                  shreg_d = dato;
               end
            end else begin
               shreg_d = SECUENCIA;
            end
         end else if (estado_q == SYNC) begin
            shreg_d    = SECUENCIA;
            sync_cnt_d = sync_cnt_q + 4'd1;
         end else begin
            // Desync word done: this load is the first sync word of the new run.
            shreg_d    = SECUENCIA;
            sync_cnt_d = 4'd1;
            estado_d   = SYNC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q   <= SYNC;
         sync_cnt_q <= '0;
         pend_q     <= 1'b0;
         s_out_q    <= 1'b0;
         sinc_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         sync_cnt_q <= sync_cnt_d;
         pend_q     <= pend_d;
         s_out_q    <= shreg_d[ANCHO-1];
         sinc_q     <= (estado_d == DATOS);
         err_q      <= err_d;
      end
      shreg_q <= shreg_d;
   end

   assign s_out        = s_out_q;
   assign sincronizado = sinc_q;
   assign error_dato   = err_q;

endmodule

// File: tb/tb_serializador_sincronia.sv
module tb_serializador_sincronia;

   localparam logic [4:0] SEC = 5'b10100;
   localparam logic [4:0] REI = 5'b00000;

   logic       clk;
   logic       rst;
   logic [4:0] dato;
   logic       dato_valido;
   logic       dato_listo;
   logic       desincronizar;
   logic       s_out;
   logic       sincronizado;
   logic       error_dato;

   typedef struct packed {
      logic b;
      logic s;
      logic e;
      logic l;
   } esp_t;

   esp_t q[$];
   int   checks  = 0;
   int   fallos  = 0;

   serializador_sincronia dut (
      .clk           (clk),
      .rst           (rst),
      .dato          (dato),
      .dato_valido   (dato_valido),
      .dato_listo    (dato_listo),
      .desincronizar (desincronizar),
      .s_out         (s_out),
      .sincronizado  (sincronizado),
      .error_dato    (error_dato)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic revisar(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         fallos++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // One edge: dato_listo checked before it, registered outputs after it.
   task automatic tick();
      esp_t e;
      revisar("cola_no_vacia", q.size() > 0, 1'b1);
      if (q.size() == 0) begin
         @(posedge clk);
         #1;
         return;
      end
      e = q.pop_front();
      #1;
      revisar("dato_listo", dato_listo, e.l);
      @(posedge clk);
      #1;
      revisar("s_out", s_out, e.b);
      revisar("sincronizado", sincronizado, e.s);
      revisar("error_dato", error_dato, e.e);
   endtask

   // Drive one word slot: inputs held for the slot, desync pulses per mask bit
   // (bit i = before edge i of the slot), expected word queued MSB first.
   task automatic palabra(input logic [4:0] w, input logic sinc, input logic err,
                          input logic listo, input logic v, input logic [4:0] d,
                          input logic [4:0] mask, input int n);
      dato        = d;
      dato_valido = v;
      for (int i = 0; i < n; i++)
         q.push_back('{w[4-i], sinc, err && (i == 0), listo && (i == 0)});
      for (int i = 0; i < n; i++) begin
         desincronizar = mask[i];
         tick();
      end
      desincronizar = 1'b0;
   endtask

   task automatic reiniciar();
      rst           = 1'b1;
      desincronizar = 1'b0;
      #1;
      revisar("listo_en_rst", dato_listo, 1'b0);
      @(posedge clk);
      #1;
      revisar("rst_s_out", s_out, 1'b0);
      revisar("rst_sincronizado", sincronizado, 1'b0);
      revisar("rst_error_dato", error_dato, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      dato          = '0;
      dato_valido   = 1'b0;
      desincronizar = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Idle after reset: two sync words, then fill; desync during SYNC ignored.
      reiniciar();
      palabra(SEC, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00100, 5);
      palabra(SEC, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 5);
      palabra(SEC, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 5);
      palabra(SEC, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 5);

      // Data held valid from reset: accepted only from the first data boundary.
      dato        = 5'b11001;
      dato_valido = 1'b1;
      reiniciar();
      palabra(SEC,      1'b0, 1'b0, 1'b0, 1'b1, 5'b11001, 5'b00000, 5);
      palabra(SEC,      1'b0, 1'b0, 1'b0, 1'b1, 5'b11001, 5'b00000, 5);
      palabra(5'b11001, 1'b1, 1'b0, 1'b1, 1'b1, 5'b11001, 5'b00000, 5);
      palabra(5'b11001, 1'b1, 1'b0, 1'b1, 1'b1, 5'b11001, 5'b00000, 5);
      palabra(SEC,      1'b1, 1'b0, 1'b1, 1'b0, 5'b11001, 5'b00000, 5);

      // Desync mid-word (second pulse ignored), then resync; pulse in REINICIO ignored.
      palabra(5'b10110, 1'b1, 1'b0, 1'b1, 1'b1, 5'b10110, 5'b01010, 5);
      palabra(REI,      1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 5'b00100, 5);
      palabra(SEC,      1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 5'b00000, 5);
      palabra(SEC,      1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 5'b00000, 5);
      palabra(5'b11111, 1'b1, 1'b0, 1'b1, 1'b1, 5'b11111, 5'b00000, 5);

      // Data word equal to the desync word: dropped, fill sent, error pulse.
      palabra(SEC,      1'b1, 1'b1, 1'b1, 1'b1, 5'b00000, 5'b00000, 5);
      palabra(5'b01101, 1'b1, 1'b0, 1'b1, 1'b1, 5'b01101, 5'b00000, 5);
      palabra(SEC,      1'b1, 1'b0, 1'b1, 1'b0, 5'b01101, 5'b00000, 5);

      // Reset in the middle of a data word: partial word lost, SYNC restarts.
      palabra(5'b10011, 1'b1, 1'b0, 1'b1, 1'b1, 5'b10011, 5'b00000, 3);
      reiniciar();
      palabra(SEC,      1'b0, 1'b0, 1'b0, 1'b1, 5'b10011, 5'b00000, 5);
      palabra(SEC,      1'b0, 1'b0, 1'b0, 1'b1, 5'b10011, 5'b00000, 5);
      palabra(5'b10011, 1'b1, 1'b0, 1'b1, 1'b1, 5'b10011, 5'b00000, 5);
      palabra(SEC,      1'b1, 1'b0, 1'b1, 1'b0, 5'b10011, 5'b00000, 5);

      revisar("cola_vacia_final", q.size() == 0, 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fallos);
      $finish;
   end

endmodule

// File: doc/serializador_sincronia.md
Name: serializador_sincronia

Overview:
- Serial framer/transmitter that generates the bit stream consumed by the team's serial sync-word detector.
- Emits fixed-width words MSB first, one bit per clock. After reset it sends the sync word SYNC_COUNT times, then sends the data words offered on a valid/ready input.
- With no data pending it sends the sync word as fill, which keeps the detector locked.
- On request it sends the reset word once to force the detector out of sync, then re-synchronises.

Parameters:
- ANCHO, 5, word width in bits.
- SECUENCIA, 5'b10100, sync/fill word; must be ANCHO bits.
- SEC_REINICIO, 5'b00000, desync word; must be ANCHO bits.
- SYNC_COUNT, 2, number of consecutive sync words sent before data is accepted (range 1..15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- dato  input  ANCHO  data word to transmit.
- dato_valido  input  1  dato holds a word to send.
- dato_listo  output  1  block accepts dato this cycle; a transfer occurs at the edge where dato_valido && dato_listo.
- desincronizar  input  1  single-cycle request to send SEC_REINICIO.
- s_out  output  1  serial stream, MSB first, registered.
- sincronizado  output  1  high while the block is in the data phase.
- error_dato  output  1  one-cycle pulse when the accepted word equals SEC_REINICIO and is dropped.

Behaviour:
- Single clock. Reset is synchronous and active-high: clk and rst are sampled on the rising edge.
- Reset values while rst=1: s_out=0, sincronizado=0, error_dato=0, dato_listo=0, bit_cnt=0, sync_cnt=0, pending desync=0, state=SYNC with a load pending.
- Shift register shreg[ANCHO-1:0] and bit_cnt 0..ANCHO-1 track the word being sent.
  - Word boundary: bit_cnt==ANCHO-1, or the first edge after rst falls.
  - At each boundary edge, the next word is loaded and its MSB is driven on s_out at that same edge.
  - At other edges, s_out takes the next lower bit.
- States and word selection at each boundary, in priority order:
  - SYNC: load SECUENCIA and increment sync_cnt. After the word that makes sync_cnt==SYNC_COUNT completes, go to DATOS. sincronizado=0 in this state.
  - DATOS, pending desync set: load SEC_REINICIO, clear the pending flag, go to REINICIO.
  - DATOS, dato_valido=1: load dato.
  - DATOS, otherwise: load SECUENCIA as fill.
  - REINICIO: after the SEC_REINICIO word completes, clear sync_cnt, return to SYNC, and deassert sincronizado.
- dato_listo is combinational and equals (boundary cycle) && state==DATOS && !pending desync && !desincronizar.
  - It is never high outside a boundary cycle.
  - Latency: the MSB of an accepted word appears on s_out at the acceptance edge. The LSB appears ANCHO-1 edges later.
- An accepted dato equal to SEC_REINICIO is not sent; SECUENCIA is loaded instead and error_dato pulses for 1 cycle. This prevents an accidental desync at the detector.
- desincronizar is captured into the pending flag at any edge. A second request while one is pending is ignored. A request during SYNC or REINICIO is ignored.
- sincronizado rises at the edge that loads the first word of the DATOS phase. It falls at the edge that loads SEC_REINICIO.
- rst=1 mid-word aborts the word immediately. Any partial word is lost and no dato is accepted in that cycle.
- Continuous streaming: back-to-back words have no gap bits, so the output rate is 1 word per ANCHO cycles.

Decomposition:
- Shared package holds:
  - state encoding: SYNC, DATOS, REINICIO;
  - default constants for SECUENCIA, SEC_REINICIO and ANCHO;
  - the bit_cnt width function (clog2 of ANCHO).
- One sub-module, contador_bits, is natural: a mod-ANCHO counter with sync clear and a "boundary" output.

Test Plan:
- Reset, then hold rst=0 with dato_valido=0 (defaults): edges 1-10 give s_out=1,0,1,0,0,1,0,1,0,0. sincronizado rises at edge 11. Fill 1,0,1,0,0 repeats after that.
- dato=5'b11001 held valid from reset: dato_listo is high only in the cycle before edge 11. Edges 11-15 give s_out=1,1,0,0,1. The word is then resent at edge 16 only while valid remains held.
- desincronizar pulsed mid-data-word: the current word completes. The next 5 bits are 0,0,0,0,0 and sincronizado falls at the first of them. Two SECUENCIA words follow, then sincronizado=1 again.
- Offer dato=5'b00000 in DATOS: the word is accepted, error_dato pulses once, and s_out sends 1,0,1,0,0.
- Assert rst for 1 cycle at bit 3 of a data word: s_out=0 during reset. The next edges restart with the SYNC sequence from bit 1, 0, 1, 0, 0.
- Loop the output into the existing sync detector bench: its valid flag asserts after the first sync word and stays high through data. It drops after the SEC_REINICIO word.
